// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
// sram_ctrl: turns single-word read/write commands into cs/oe/we strobe sequences
// for an asynchronous SRAM, with byte masking, setup/hold, bus turnaround and range check.
module sram_ctrl #(
  parameter int ADDR_BITS   = 18,
  parameter int DATA_BITS   = 16,
  parameter int BE_BITS     = DATA_BITS / 8,
  parameter int MEM_DEPTH   = 262144,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  input  logic [BE_BITS-1:0]   cmd_be,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 wr_done,
  output logic                 cmd_err,
  output logic [ADDR_BITS-1:0] sram_addr,
  inout  wire  [DATA_BITS-1:0] sram_data,
  output logic                 sram_cs_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [BE_BITS-1:0]   sram_be_n
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_SETUP  = 3'd1;
  localparam logic [2:0] S_WR_STROBE = 3'd2;
  localparam logic [2:0] S_WR_HOLD   = 3'd3;
  localparam logic [2:0] S_RD_STROBE = 3'd4;

  localparam int CNT_BITS = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WAIT_CYCLES - 1);
  // One extra bit so a depth equal to the full address space never flags an error.
  localparam int LIM_BITS = ADDR_BITS + 1;
  localparam logic [LIM_BITS-1:0] DEPTH_LIM = LIM_BITS'(MEM_DEPTH);

  logic [2:0]           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [BE_BITS-1:0]   be_n_q, be_n_d;
  logic                 cs_n_q, cs_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 drive_q, drive_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 in_range;

  assign in_range = ({1'b0, cmd_addr} < DEPTH_LIM);

  // Pin values are computed for the state being entered, so every SRAM pin is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    be_n_d     = be_n_q;
    cs_n_d     = cs_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    drive_d    = drive_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    cmd_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!in_range) begin
            cmd_err_d = 1'b1;
          end else if (cmd_we) begin
            state_d = S_WR_SETUP;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            be_n_d  = ~cmd_be;
            cs_n_d  = 1'b0;
            drive_d = 1'b1;
          end else begin
            state_d = S_RD_STROBE;
            cnt_d   = CNT_LAST;
            addr_d  = cmd_addr;
            be_n_d  = '0;
            cs_n_d  = 1'b0;
            oe_n_d  = 1'b0;
          end
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_STROBE;
        cnt_d   = CNT_LAST;
        we_n_d  = 1'b0;
      end
      S_WR_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      S_WR_HOLD: begin
        state_d   = S_IDLE;
        cs_n_d    = 1'b1;
        be_n_d    = '1;
        drive_d   = 1'b0;
        wr_done_d = 1'b1;
      end
      S_RD_STROBE: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          cs_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          be_n_d     = '1;
          rd_data_d  = sram_data;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      be_n_q     <= '1;
      cs_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      be_n_q     <= be_n_d;
      cs_n_q     <= cs_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drive_q    <= drive_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_done   = wr_done_q;
  assign cmd_err   = cmd_err_q;
  assign sram_addr = addr_q;
  assign sram_cs_n = cs_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;

  genvar gi;
  generate
    for (gi = 0; gi < BE_BITS; gi++) begin : g_lane
      assign sram_data[gi*8 +: 8] = drive_q ? wdata_q[gi*8 +: 8] : 8'bz;
    end
  endgenerate

endmodule
